// File: rtl/mario_motion.sv
// rtl/mario_motion.sv - Per-frame walk/jump/fall position controller for the Mario sprite.
// Define MARIO_XWRAP_EN to wrap horizontal motion at the screen edges instead of clamping.
module mario_motion #(
    parameter int X_INIT    = 100,
    parameter int GROUND_Y  = 384,
    parameter int SIZE      = 16,
    parameter int X_STEP    = 2,
    parameter int JUMP_V    = 10,
    parameter int GRAVITY   = 1,
    parameter int VMAX_FALL = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    output logic [9:0] MarioX,
    output logic [9:0] MarioY,
    output logic [9:0] Mario_size,
    output logic       facing_left,
    output logic       airborne,
    output logic       tick_o
);
    typedef enum logic [1:0] {S_GROUND, S_RISE, S_FALL} state_t;

    localparam logic signed [10:0] L_XMAX   = 11'(640 - SIZE);
    localparam logic signed [10:0] L_XSTEP  = 11'(X_STEP);
    localparam logic signed [10:0] L_GROUND = 11'(GROUND_Y);
    localparam logic signed [7:0]  L_GRAV   = 8'(GRAVITY);
    localparam logic signed [7:0]  L_VMAX   = 8'(VMAX_FALL);

    logic              r_sync1, r_sync2, r_prev, r_tick;
    state_t            r_state, w_state_next;
    logic [9:0]        r_x, r_y, w_x_next, w_y_next;
    logic signed [7:0] r_vy, w_vy_next, w_vy_inc;
    logic              r_face, r_armed, w_face_next, w_armed_next;
    logic              w_tick, w_left, w_right, w_jump;
    logic signed [10:0] w_x_step, w_y_sum;

    assign w_tick  = r_sync2 & ~r_prev;
    assign w_left  = (keycode0 == 8'h04) || (keycode1 == 8'h04);
    assign w_right = (keycode0 == 8'h07) || (keycode1 == 8'h07);
    assign w_jump  = (keycode0 == 8'h1A) || (keycode1 == 8'h1A);

    // Horizontal: signed 11-bit so stepping left of 0 is seen as negative.
    always_comb begin
        w_x_step    = $signed({1'b0, r_x});
        w_face_next = r_face;
        if (w_left && !w_right) begin
            w_x_step    = $signed({1'b0, r_x}) - L_XSTEP;
            w_face_next = 1'b1;
        end else if (w_right && !w_left) begin
            w_x_step    = $signed({1'b0, r_x}) + L_XSTEP;
            w_face_next = 1'b0;
        end
        w_x_next = w_x_step[9:0];
`ifdef MARIO_XWRAP_EN
        if (w_x_step < 0)
            w_x_next = 10'(w_x_step + L_XMAX + 11'sd1);
        else if (w_x_step > L_XMAX)
            w_x_next = 10'(w_x_step - L_XMAX - 11'sd1);
`else
        if (w_x_step < 0)
            w_x_next = 10'd0;
        else if (w_x_step > L_XMAX)
            w_x_next = L_XMAX[9:0];
`endif
    end

    assign w_y_sum  = $signed({1'b0, r_y}) + $signed({{3{r_vy[7]}}, r_vy});
    assign w_vy_inc = r_vy + L_GRAV;

    always_comb begin
        w_state_next = r_state;
        w_y_next     = r_y;
        w_vy_next    = r_vy;
        w_armed_next = r_armed | ~w_jump;
        case (r_state)
            S_GROUND: begin
                if (w_jump && r_armed) begin
                    w_y_next     = 10'(GROUND_Y - JUMP_V);
                    w_vy_next    = 8'(GRAVITY - JUMP_V);
                    w_armed_next = 1'b0;
                    w_state_next = S_RISE;
                end else begin
                    w_y_next = L_GROUND[9:0];
                end
            end
            S_RISE: begin
                if (w_y_sum < 0) begin
                    w_y_next     = 10'd0;
                    w_vy_next    = 8'sd0;
                    w_state_next = S_FALL;
                end else begin
                    w_y_next  = w_y_sum[9:0];
                    w_vy_next = w_vy_inc;
                    if (!w_vy_inc[7])
                        w_state_next = S_FALL;
                end
            end
            S_FALL: begin
                if (w_y_sum >= L_GROUND) begin
                    w_y_next     = L_GROUND[9:0];
                    w_vy_next    = 8'sd0;
                    w_state_next = S_GROUND;
                end else begin
                    w_y_next  = w_y_sum[9:0];
                    w_vy_next = (w_vy_inc > L_VMAX) ? L_VMAX : w_vy_inc;
                end
            end
            default: w_state_next = S_GROUND;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_tick  <= 1'b0;
            r_state <= S_GROUND;
            r_x     <= 10'(X_INIT);
            r_y     <= 10'(GROUND_Y);
            r_vy    <= 8'sd0;
            r_face  <= 1'b0;
            r_armed <= 1'b1;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tick  <= w_tick;
            if (w_tick) begin
                r_state <= w_state_next;
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_vy    <= w_vy_next;
                r_face  <= w_face_next;
                r_armed <= w_armed_next;
            end
        end
    end

    assign MarioX      = r_x;
    assign MarioY      = r_y;
    assign Mario_size  = 10'(SIZE);
    assign facing_left = r_face;
    assign airborne    = (r_state != S_GROUND);
    assign tick_o      = r_tick;
endmodule

// File: tb/tb_mario_motion.sv
// tb/tb_mario_motion.sv - Directed and random frame stimulus against a physics reference model.
module tb_mario_motion;
    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode0 = 8'h00;
    logic [7:0] keycode1 = 8'h00;
    logic [9:0] MarioX, MarioY, Mario_size;
    logic       facing_left, airborne, tick_o;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference physics state in plain integers.
    int m_x, m_y, m_vy, m_face, m_air, m_rise, m_armed;
    int ys[0:15];

    mario_motion dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .keycode0(keycode0), .keycode1(keycode1),
        .MarioX(MarioX), .MarioY(MarioY), .Mario_size(Mario_size),
        .facing_left(facing_left), .airborne(airborne), .tick_o(tick_o)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 100; m_y = 384; m_vy = 0; m_face = 0; m_air = 0; m_rise = 0; m_armed = 1;
    endtask

    task automatic model_step(input logic [7:0] k0, input logic [7:0] k1);
        bit l, r, w;
        l = (k0 == 8'h04) || (k1 == 8'h04);
        r = (k0 == 8'h07) || (k1 == 8'h07);
        w = (k0 == 8'h1A) || (k1 == 8'h1A);
        if (l && !r) begin m_x = m_x - 2; m_face = 1; end
        else if (r && !l) begin m_x = m_x + 2; m_face = 0; end
        if (m_x < 0) m_x = 0;
        if (m_x > 624) m_x = 624;
        if (!m_air) begin
            if (w && m_armed) begin
                m_y = 374; m_vy = -9; m_air = 1; m_rise = 1; m_armed = 0;
            end else m_y = 384;
        end else if (m_rise) begin
            if (m_y + m_vy < 0) begin m_y = 0; m_vy = 0; m_rise = 0; end
            else begin
                m_y = m_y + m_vy; m_vy = m_vy + 1;
                if (m_vy >= 0) m_rise = 0;
            end
        end else begin
            if (m_y + m_vy >= 384) begin m_y = 384; m_vy = 0; m_air = 0; end
            else begin
                m_y = m_y + m_vy;
                m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
            end
        end
        if (!w) m_armed = 1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_x"}, 32'(MarioX), 32'(m_x));
        chk({tag, "_y"}, 32'(MarioY), 32'(m_y));
        chk({tag, "_face"}, 32'(facing_left), 32'(m_face));
        chk({tag, "_air"}, 32'(airborne), 32'(m_air));
    endtask

    task automatic do_frame(input logic [7:0] k0, input logic [7:0] k1);
        bit seen;
        int extra;
        logic [7:0] junk [0:3];
        junk[0] = 8'h04; junk[1] = 8'h07; junk[2] = 8'h1A; junk[3] = 8'h00;
        keycode0 = k0;
        keycode1 = k1;
        @(negedge Clk);
        #3 frame_clk = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 12 && !seen; n++) begin
            @(negedge Clk);
            if (tick_o === 1'b1) seen = 1'b1;
        end
        chk("tick_seen", 32'(seen), 32'd1);
        model_step(k0, k1);
        check_model("frame");
        #3 frame_clk = 1'b0;
        keycode0 = junk[$urandom_range(0, 3)];
        keycode1 = junk[$urandom_range(0, 3)];
        extra = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge Clk);
            if (tick_o !== 1'b0) extra++;
        end
        chk("tick_single", 32'(extra), 32'd0);
        chk("idle_x", 32'(MarioX), 32'(m_x));
        chk("idle_y", 32'(MarioY), 32'(m_y));
    endtask

    initial begin
        logic [7:0] pool [0:5];
        int tick_cnt;
        pool[0] = 8'h00; pool[1] = 8'h04; pool[2] = 8'h07;
        pool[3] = 8'h1A; pool[4] = 8'h1A; pool[5] = 8'h55;

        // Reset with keys held, then no frame strobe
        keycode0 = 8'h07;
        keycode1 = 8'h1A;
        model_reset();
        repeat (3) @(negedge Clk);
        check_model("in_reset");
        chk("in_reset_tick", 32'(tick_o), 32'd0);
        Reset_n = 1'b1;
        tick_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge Clk);
            if (tick_o !== 1'b0) tick_cnt++;
        end
        chk("no_frame_ticks", 32'(tick_cnt), 32'd0);
        chk("rst_x", 32'(MarioX), 32'd100);
        chk("rst_y", 32'(MarioY), 32'd384);
        chk("rst_air", 32'(airborne), 32'd0);
        chk("size", 32'(Mario_size), 32'd16);

        // Walk right to the clamp
        for (int i = 0; i < 300; i++) do_frame(8'h07, 8'h00);
        chk("right_sat", 32'(MarioX), 32'd624);
        chk("right_face", 32'(facing_left), 32'd0);

        // Walk left to the clamp via slot 1
        for (int i = 0; i < 320; i++) do_frame(8'h00, 8'h04);
        chk("left_sat", 32'(MarioX), 32'd0);
        chk("left_face", 32'(facing_left), 32'd1);

        // Single-frame jump: arc and landing
        do_frame(8'h1A, 8'h00);
        ys[0] = int'(MarioY);
        for (int i = 1; i < 10; i++) begin
            do_frame(8'h00, 8'h00);
            ys[i] = int'(MarioY);
        end
        chk("jump_y1", 32'(ys[0]), 32'd374);
        chk("jump_y2", 32'(ys[1]), 32'd365);
        chk("jump_y3", 32'(ys[2]), 32'd357);
        chk("jump_apex", 32'(ys[9]), 32'd329);
        chk("jump_air", 32'(airborne), 32'd1);
        for (int i = 0; i < 20; i++) do_frame(8'h00, 8'h00);
        chk("land_y", 32'(MarioY), 32'd384);
        chk("land_air", 32'(airborne), 32'd0);

        // Hold W through the landing: no auto-repeat
        for (int i = 0; i < 40; i++) do_frame(8'h00, 8'h1A);
        chk("hold_no_rejump", 32'(airborne), 32'd0);
        do_frame(8'h00, 8'h00);
        do_frame(8'h1A, 8'h00);
        chk("rearm_jump", 32'(MarioY), 32'd374);
        for (int i = 0; i < 25; i++) do_frame(8'h00, 8'h00);

        // Opposing keys cancel
        do_frame(8'h07, 8'h00);
        do_frame(8'h04, 8'h07);
        chk("both_keys_x", 32'(MarioX), 32'd2);

        // Random key pairs against the model
        for (int i = 0; i < 400; i++)
            do_frame(pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]);

        // Asynchronous reset mid-rise
        for (int i = 0; i < 30; i++) do_frame(8'h00, 8'h00);
        do_frame(8'h1A, 8'h07);
        do_frame(8'h00, 8'h07);
        chk("pre_reset_air", 32'(airborne), 32'd1);
        @(negedge Clk);
        #4 Reset_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge Clk);
        Reset_n = 1'b1;
        do_frame(8'h00, 8'h00);
        chk("post_rst_y", 32'(MarioY), 32'd384);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
